mini_core_dmem_arb: RTL and testbench

- Data-memory access controller for mini_core. Sits between the pipeline's Q103H memory stage and the core's single-port local data memory (D_MEM).
- Shares D_MEM between the core and an external (tile/fabric) requester using core-priority arbitration with a starvation guard.
- Sends core accesses outside the local window to the fabric port through a small FSM.
- Generates DMemReady, the core-wide back-pressure that freezes all pipe stages while low.

---
 rtl/mini_core_pkg.sv | 34 +++
 rtl/mini_core_dmem_starve_cnt.sv | 31 +++
 rtl/mini_core_dmem_arb.sv | 131 +++++++++++++
 tb/tb_mini_core_dmem_arb.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_core_pkg.sv
// rtl/mini_core_pkg.sv - shared mini_core types and flop macros
`ifndef MAFIA_RST_DFF
`define MAFIA_RST_DFF(q, d, rv, clk, rst) \
  always_ff @(posedge clk) begin \
    if (rst) q <= rv; \
    else q <= d; \
  end
`endif

`ifndef MAFIA_EN_RST_DFF
`define MAFIA_EN_RST_DFF(q, d, en, rv, clk, rst) \
  always_ff @(posedge clk) begin \
    if (rst) q <= rv; \
    else if (en) q <= d; \
  end
`endif

package mini_core_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FAB_REQ,
    S_FAB_RSP,
    S_FAB_DONE
  } t_dmem_arb_state;

  typedef struct packed {
    logic        WrEn;
    logic [31:0] Addr;
    logic [31:0] WrData;
    logic [3:0]  ByteEn;
  } t_dmem_req;

endpackage

// File: rtl/mini_core_dmem_starve_cnt.sv
// rtl/mini_core_dmem_starve_cnt.sv - saturating count of blocked external cycles
module mini_core_dmem_starve_cnt
  import mini_core_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic Clock,
  input  logic Rst,
  input  logic ReqValid,
  input  logic Granted,
  input  logic CountEn,
  output logic Force
);

  logic [3:0] cnt;
  logic [3:0] cntNxt;

  always_comb begin
    cntNxt = cnt;
    if (!ReqValid || Granted) begin
      cntNxt = '0;
    end else if (CountEn && (cnt != 4'(MAX))) begin
      cntNxt = cnt + 4'd1;
    end
  end

  `MAFIA_RST_DFF(cnt, cntNxt, 4'd0, Clock, Rst)

  assign Force = ReqValid && (cnt == 4'(MAX));

endmodule

// File: rtl/mini_core_dmem_arb.sv
// rtl/mini_core_dmem_arb.sv - D_MEM arbiter, fabric bridge FSM and pipe back-pressure
module mini_core_dmem_arb
  import mini_core_pkg::*;
#(
  parameter logic [31:0] LOCAL_BASE      = 32'h0001_0000,
  parameter int          LOCAL_SIZE_LOG2 = 14,
  parameter int          EXT_STARVE_MAX  = 4
) (
  input  logic                       Clock,
  input  logic                       Rst,
  input  logic                       CoreRdEnQ103H,
  input  logic                       CoreWrEnQ103H,
  input  logic [31:0]                CoreAddrQ103H,
  input  logic [31:0]                CoreWrDataQ103H,
  input  logic [3:0]                 CoreByteEnQ103H,
  output logic [31:0]                CoreRdDataQ104H,
  output logic                       DMemReady,
  input  logic                       ExtReqValid,
  output logic                       ExtReqReady,
  input  logic                       ExtWrEn,
  input  logic [LOCAL_SIZE_LOG2-3:0] ExtAddr,
  input  logic [31:0]                ExtWrData,
  input  logic [3:0]                 ExtByteEn,
  output logic                       ExtRspValid,
  output logic [31:0]                ExtRspData,
  output logic                       MemEn,
  output logic                       MemWrEn,
  output logic [LOCAL_SIZE_LOG2-3:0] MemAddr,
  output logic [31:0]                MemWrData,
  output logic [3:0]                 MemByteEn,
  input  logic [31:0]                MemRdData,
  output logic                       FabReqValid,
  input  logic                       FabReqReady,
  output logic                       FabReqWrEn,
  output logic [31:0]                FabReqAddr,
  output logic [31:0]                FabReqWrData,
  output logic [3:0]                 FabReqByteEn,
  input  logic                       FabRspValid,
  input  logic [31:0]                FabRspData
);

  t_dmem_arb_state state;
  t_dmem_arb_state stateNxt;
  t_dmem_req       fabReq;
  t_dmem_req       fabReqNxt;
  logic [31:0]     rdHold;
  logic            coreRdPend;
  logic            extRdPend;

  logic coreAcc;
  logic isLocal;
  logic isIdle;
  logic extForce;
  logic coreGrant;
  logic extGrant;
  logic fabStart;
  logic fabRspTake;

  assign coreAcc    = CoreRdEnQ103H | CoreWrEnQ103H;
  assign isLocal    = CoreAddrQ103H[31:LOCAL_SIZE_LOG2] == LOCAL_BASE[31:LOCAL_SIZE_LOG2];
  assign isIdle     = state == S_IDLE;
  assign coreGrant  = !Rst && isIdle && coreAcc && isLocal && !extForce;
  // D_MEM is idle in every non-IDLE state, so the external side wins there unconditionally.
  assign extGrant   = !Rst && ExtReqValid && !coreGrant;
  assign fabStart   = isIdle && coreAcc && !isLocal;
  assign fabRspTake = (state == S_FAB_RSP) && FabRspValid;

  mini_core_dmem_starve_cnt #(
    .MAX(EXT_STARVE_MAX)
  ) u_starve_cnt (
    .Clock   (Clock),
    .Rst     (Rst),
    .ReqValid(ExtReqValid),
    .Granted (extGrant),
    .CountEn (isIdle),
    .Force   (extForce)
  );

  always_comb begin
    stateNxt = state;
    case (state)
      S_IDLE:     if (fabStart) stateNxt = S_FAB_REQ;
      S_FAB_REQ:  if (FabReqReady) stateNxt = fabReq.WrEn ? S_IDLE : S_FAB_RSP;
      S_FAB_RSP:  if (FabRspValid) stateNxt = S_FAB_DONE;
      S_FAB_DONE: stateNxt = S_IDLE;
      default:    stateNxt = S_IDLE;
    endcase
  end

  assign fabReqNxt = '{WrEn: CoreWrEnQ103H, Addr: CoreAddrQ103H,
                       WrData: CoreWrDataQ103H, ByteEn: CoreByteEnQ103H};

  `MAFIA_RST_DFF(state, stateNxt, S_IDLE, Clock, Rst)
  `MAFIA_EN_RST_DFF(fabReq, fabReqNxt, fabStart, '0, Clock, Rst)
  `MAFIA_RST_DFF(coreRdPend, coreGrant && CoreRdEnQ103H, 1'b0, Clock, Rst)
  `MAFIA_RST_DFF(extRdPend, extGrant && !ExtWrEn, 1'b0, Clock, Rst)
  // Only loads that actually completed touch the hold register, so a stolen cycle leaves Q104H intact.
  `MAFIA_EN_RST_DFF(rdHold, coreRdPend ? MemRdData : FabRspData, coreRdPend || fabRspTake, 32'd0, Clock, Rst)

  always_comb begin
    DMemReady = 1'b1;
    if (!Rst) begin
      case (state)
        S_IDLE:    DMemReady = !coreAcc || (isLocal && !extForce);
        S_FAB_REQ: DMemReady = FabReqReady && fabReq.WrEn;
        S_FAB_RSP: DMemReady = 1'b0;
        default:   DMemReady = 1'b1;
      endcase
    end
  end

  assign MemEn     = coreGrant || extGrant;
  assign MemWrEn   = coreGrant ? CoreWrEnQ103H : (extGrant && ExtWrEn);
  assign MemAddr   = coreGrant ? CoreAddrQ103H[LOCAL_SIZE_LOG2-1:2] : ExtAddr;
  assign MemWrData = coreGrant ? CoreWrDataQ103H : ExtWrData;
  assign MemByteEn = coreGrant ? CoreByteEnQ103H : ExtByteEn;

  assign ExtReqReady     = extGrant;
  assign ExtRspValid     = extRdPend && !Rst;
  assign ExtRspData      = ExtRspValid ? MemRdData : 32'd0;
  assign CoreRdDataQ104H = Rst ? 32'd0 : (coreRdPend ? MemRdData : rdHold);

  assign FabReqValid  = !Rst && (state == S_FAB_REQ);
  assign FabReqWrEn   = fabReq.WrEn;
  assign FabReqAddr   = fabReq.Addr;
  assign FabReqWrData = fabReq.WrData;
  assign FabReqByteEn = fabReq.ByteEn;

  assert property (@(posedge Clock) disable iff (Rst) !(CoreRdEnQ103H && CoreWrEnQ103H));

endmodule

// File: tb/tb_mini_core_dmem_arb.sv
// tb/tb_mini_core_dmem_arb.sv - self-checking bench for mini_core_dmem_arb
module tb_mini_core_dmem_arb;
  localparam logic [31:0] LOCAL_BASE = 32'h0001_0000;
  localparam int LSZ    = 14;
  localparam int AW     = LSZ - 2;
  localparam int STARVE = 4;

  logic          Clock = 1'b0;
  logic          Rst;
  logic          CoreRdEnQ103H, CoreWrEnQ103H;
  logic [31:0]   CoreAddrQ103H, CoreWrDataQ103H;
  logic [3:0]    CoreByteEnQ103H;
  logic [31:0]   CoreRdDataQ104H;
  logic          DMemReady;
  logic          ExtReqValid, ExtReqReady, ExtWrEn;
  logic [AW-1:0] ExtAddr;
  logic [31:0]   ExtWrData;
  logic [3:0]    ExtByteEn;
  logic          ExtRspValid;
  logic [31:0]   ExtRspData;
  logic          MemEn, MemWrEn;
  logic [AW-1:0] MemAddr;
  logic [31:0]   MemWrData;
  logic [3:0]    MemByteEn;
  logic [31:0]   MemRdData;
  logic          FabReqValid, FabReqReady, FabReqWrEn;
  logic [31:0]   FabReqAddr, FabReqWrData;
  logic [3:0]    FabReqByteEn;
  logic          FabRspValid;
  logic [31:0]   FabRspData;

  int checks = 0;
  int errors = 0;
  logic [31:0] dmem   [0:4095];
  logic [31:0] refMem [0:4095];
  logic [31:0] coreExp;

  mini_core_dmem_arb #(
    .LOCAL_BASE(LOCAL_BASE), .LOCAL_SIZE_LOG2(LSZ), .EXT_STARVE_MAX(STARVE)
  ) dut (
    .Clock(Clock), .Rst(Rst),
    .CoreRdEnQ103H(CoreRdEnQ103H), .CoreWrEnQ103H(CoreWrEnQ103H), .CoreAddrQ103H(CoreAddrQ103H),
    .CoreWrDataQ103H(CoreWrDataQ103H), .CoreByteEnQ103H(CoreByteEnQ103H),
    .CoreRdDataQ104H(CoreRdDataQ104H), .DMemReady(DMemReady),
    .ExtReqValid(ExtReqValid), .ExtReqReady(ExtReqReady), .ExtWrEn(ExtWrEn), .ExtAddr(ExtAddr),
    .ExtWrData(ExtWrData), .ExtByteEn(ExtByteEn), .ExtRspValid(ExtRspValid), .ExtRspData(ExtRspData),
    .MemEn(MemEn), .MemWrEn(MemWrEn), .MemAddr(MemAddr), .MemWrData(MemWrData),
    .MemByteEn(MemByteEn), .MemRdData(MemRdData),
    .FabReqValid(FabReqValid), .FabReqReady(FabReqReady), .FabReqWrEn(FabReqWrEn),
    .FabReqAddr(FabReqAddr), .FabReqWrData(FabReqWrData), .FabReqByteEn(FabReqByteEn),
    .FabRspValid(FabRspValid), .FabRspData(FabRspData)
  );

  always #5 Clock = ~Clock;

  // Single-port D_MEM with one-cycle read latency
  initial for (int i = 0; i < 4096; i++) dmem[i] = 32'hA500_0000 | 32'(i);

  always @(posedge Clock) begin
    if (MemEn) begin
      if (MemWrEn) begin
        for (int b = 0; b < 4; b++)
          if (MemByteEn[b]) dmem[MemAddr][8*b +: 8] = MemWrData[8*b +: 8];
      end else begin
        MemRdData <= dmem[MemAddr];
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] localAddr(input int w);
    return LOCAL_BASE + 32'(w) * 32'd4;
  endfunction

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic clearInputs();
    CoreRdEnQ103H = 0; CoreWrEnQ103H = 0; CoreAddrQ103H = '0; CoreWrDataQ103H = '0; CoreByteEnQ103H = '0;
    ExtReqValid = 0; ExtWrEn = 0; ExtAddr = '0; ExtWrData = '0; ExtByteEn = '0;
    FabReqReady = 0; FabRspValid = 0; FabRspData = '0;
  endtask

  task automatic test_reset();
    CoreRdEnQ103H = 1; CoreAddrQ103H = localAddr(5); CoreByteEnQ103H = 4'hF;
    ExtReqValid = 1; ExtAddr = 12'd3; FabRspValid = 1; FabRspData = $urandom;
    @(negedge Clock);
    checks++; if (DMemReady !== 1'b1) begin errors++; $display("FAIL reset_dmemready got %b exp 1", DMemReady); end
    checks++; if (ExtReqReady !== 1'b0) begin errors++; $display("FAIL reset_extready got %b exp 0", ExtReqReady); end
    checks++; if (ExtRspValid !== 1'b0) begin errors++; $display("FAIL reset_extrspvalid got %b exp 0", ExtRspValid); end
    checks++; if (MemEn !== 1'b0) begin errors++; $display("FAIL reset_memen got %b exp 0", MemEn); end
    checks++; if (FabReqValid !== 1'b0) begin errors++; $display("FAIL reset_fabvalid got %b exp 0", FabReqValid); end
    checks++; if (ExtRspData !== 32'd0) begin errors++; $display("FAIL reset_extrspdata got %h exp 0", ExtRspData); end
    checks++; if (CoreRdDataQ104H !== 32'd0) begin errors++; $display("FAIL reset_corerd got %h exp 0", CoreRdDataQ104H); end
    cyc();
    Rst = 0; clearInputs(); coreExp = 32'd0;
  endtask

  task automatic test_core_load();
    ExtReqValid = 1; ExtWrEn = 1; ExtAddr = 12'd4; ExtWrData = 32'hDEADBEEF; ExtByteEn = 4'hF;
    @(negedge Clock);
    checks++; if (ExtReqReady !== 1'b1) begin errors++; $display("FAIL preload_extready got %b exp 1", ExtReqReady); end
    refMem[4] = merge(refMem[4], 32'hDEADBEEF, 4'hF);
    cyc(); clearInputs();
    CoreRdEnQ103H = 1; CoreAddrQ103H = LOCAL_BASE + 32'h10; CoreByteEnQ103H = 4'hF;
    @(negedge Clock);
    checks++; if (MemEn !== 1'b1 || MemWrEn !== 1'b0) begin errors++; $display("FAIL lw_memen got %b/%b exp 1/0", MemEn, MemWrEn); end
    checks++; if (MemAddr !== 12'd4) begin errors++; $display("FAIL lw_memaddr got %h exp 4", MemAddr); end
    checks++; if (DMemReady !== 1'b1) begin errors++; $display("FAIL lw_ready got %b exp 1", DMemReady); end
    cyc(); clearInputs();
    @(negedge Clock);
    checks++; if (CoreRdDataQ104H !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", CoreRdDataQ104H); end
    cyc();
    @(negedge Clock);
    checks++; if (CoreRdDataQ104H !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_hold got %h exp deadbeef", CoreRdDataQ104H); end
    coreExp = 32'hDEADBEEF;
    cyc();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 40; c++) begin
      int op, w;
      logic [31:0] d;
      logic [3:0] be;
      op = $urandom_range(0, 2); w = $urandom_range(0, 15); d = $urandom; be = 4'($urandom);
      clearInputs();
      CoreRdEnQ103H = (op == 1); CoreWrEnQ103H = (op == 2);
      CoreAddrQ103H = localAddr(w); CoreWrDataQ103H = d; CoreByteEnQ103H = be;
      @(negedge Clock);
      checks++; if (DMemReady !== 1'b1) begin errors++; $display("FAIL b2b_ready c=%0d got %b exp 1", c, DMemReady); end
      checks++; if (CoreRdDataQ104H !== coreExp) begin errors++; $display("FAIL b2b_data c=%0d got %h exp %h", c, CoreRdDataQ104H, coreExp); end
      if (op == 1) coreExp = refMem[w];
      if (op == 2) refMem[w] = merge(refMem[w], d, be);
      cyc();
    end
    clearInputs();
    @(negedge Clock);
    checks++; if (CoreRdDataQ104H !== coreExp) begin errors++; $display("FAIL b2b_last got %h exp %h", CoreRdDataQ104H, coreExp); end
    cyc();
  endtask

  task automatic test_starvation();
    int blocked = 0;
    int coreW, extW;
    logic extWr, extPendRd, grantExp;
    logic [31:0] extD, extExp;
    logic [3:0] extBe;
    extPendRd = 0; extExp = '0;
    coreW = $urandom_range(0, 15);
    extW = $urandom_range(0, 15); extWr = 1'($urandom); extD = $urandom; extBe = 4'($urandom);
    for (int c = 0; c < 20; c++) begin
      clearInputs();
      CoreRdEnQ103H = 1; CoreAddrQ103H = localAddr(coreW); CoreByteEnQ103H = 4'hF;
      ExtReqValid = 1; ExtWrEn = extWr; ExtAddr = AW'(extW); ExtWrData = extD; ExtByteEn = extBe;
      @(negedge Clock);
      grantExp = (blocked == STARVE);
      checks++; if (ExtReqReady !== grantExp) begin errors++; $display("FAIL starve_grant c=%0d got %b exp %b", c, ExtReqReady, grantExp); end
      checks++; if (DMemReady !== !grantExp) begin errors++; $display("FAIL starve_ready c=%0d got %b exp %b", c, DMemReady, !grantExp); end
      checks++; if (CoreRdDataQ104H !== coreExp) begin errors++; $display("FAIL starve_core c=%0d got %h exp %h", c, CoreRdDataQ104H, coreExp); end
      checks++; if (ExtRspValid !== extPendRd) begin errors++; $display("FAIL starve_rspvalid c=%0d got %b exp %b", c, ExtRspValid, extPendRd); end
      if (extPendRd) begin
        checks++; if (ExtRspData !== extExp) begin errors++; $display("FAIL starve_rspdata c=%0d got %h exp %h", c, ExtRspData, extExp); end
      end
      extPendRd = 0;
      if (grantExp) begin
        blocked = 0;
        if (extWr) refMem[extW] = merge(refMem[extW], extD, extBe);
        else begin extPendRd = 1; extExp = refMem[extW]; end
        extW = $urandom_range(0, 15); extWr = 1'($urandom); extD = $urandom; extBe = 4'($urandom);
      end else begin
        blocked++;
        coreExp = refMem[coreW];
        coreW = $urandom_range(0, 15);
      end
      cyc();
    end
    clearInputs();
    @(negedge Clock);
    checks++; if (ExtRspValid !== extPendRd) begin errors++; $display("FAIL starve_tail got %b exp %b", ExtRspValid, extPendRd); end
    checks++; if (CoreRdDataQ104H !== coreExp) begin errors++; $display("FAIL starve_tail_core got %h exp %h", CoreRdDataQ104H, coreExp); end
    cyc();
  endtask

  task automatic test_fab_load(input int reqWait, input int rspWait, input logic [31:0] addr, input logic [31:0] data);
    int total, lowCnt;
    total = reqWait + rspWait;
    lowCnt = 0;
    for (int k = 0; k <= total + 2; k++) begin
      clearInputs();
      CoreRdEnQ103H = (k <= total + 1); CoreAddrQ103H = addr; CoreByteEnQ103H = 4'hF;
      FabReqReady = (k == reqWait);
      FabRspValid = (k == total) || (k == 0);
      FabRspData = (k == total) ? data : ~data;
      @(negedge Clock);
      if (DMemReady === 1'b0) lowCnt++;
      checks++; if (DMemReady !== (k >= total + 1)) begin errors++; $display("FAIL fabld_ready k=%0d got %b exp %b", k, DMemReady, k >= total + 1); end
      checks++; if (FabReqValid !== (k >= 1 && k <= reqWait)) begin errors++; $display("FAIL fabld_valid k=%0d got %b", k, FabReqValid); end
      if (k == 1) begin
        checks++; if (FabReqAddr !== addr || FabReqWrEn !== 1'b0) begin errors++; $display("FAIL fabld_req got %h/%b exp %h/0", FabReqAddr, FabReqWrEn, addr); end
      end
      if (k <= total) begin
        checks++; if (CoreRdDataQ104H !== coreExp) begin errors++; $display("FAIL fabld_frozen k=%0d got %h exp %h", k, CoreRdDataQ104H, coreExp); end
      end
      if (k == total + 2) begin
        checks++; if (CoreRdDataQ104H !== data) begin errors++; $display("FAIL fabld_data got %h exp %h", CoreRdDataQ104H, data); end
      end
      cyc();
    end
    coreExp = data;
    checks++; if (lowCnt != total + 1) begin errors++; $display("FAIL fabld_lowcnt got %0d exp %0d", lowCnt, total + 1); end
  endtask

  task automatic test_fab_store();
    logic [31:0] addr, d;
    logic [3:0] be;
    addr = 32'h0300_0000 + 32'($urandom_range(0, 255)) * 4; d = $urandom; be = 4'($urandom_range(1, 15));
    clearInputs();
    CoreWrEnQ103H = 1; CoreAddrQ103H = addr; CoreWrDataQ103H = d; CoreByteEnQ103H = be;
    @(negedge Clock);
    checks++; if (DMemReady !== 1'b0 || FabReqValid !== 1'b0) begin errors++; $display("FAIL fabst_detect got %b/%b exp 0/0", DMemReady, FabReqValid); end
    cyc();
    FabReqReady = 1;
    @(negedge Clock);
    checks++; if (FabReqValid !== 1'b1 || FabReqWrEn !== 1'b1) begin errors++; $display("FAIL fabst_valid got %b/%b exp 1/1", FabReqValid, FabReqWrEn); end
    checks++; if (FabReqWrData !== d || FabReqByteEn !== be || FabReqAddr !== addr) begin errors++; $display("FAIL fabst_fields got %h/%h/%h exp %h/%h/%h", FabReqWrData, FabReqByteEn, FabReqAddr, d, be, addr); end
    checks++; if (DMemReady !== 1'b1) begin errors++; $display("FAIL fabst_handshake got %b exp 1", DMemReady); end
    cyc(); clearInputs();
    CoreRdEnQ103H = 1; CoreAddrQ103H = localAddr(3); CoreByteEnQ103H = 4'hF;
    @(negedge Clock);
    checks++; if (FabReqValid !== 1'b0 || DMemReady !== 1'b1 || MemEn !== 1'b1) begin errors++; $display("FAIL fabst_idle got %b/%b/%b exp 0/1/1", FabReqValid, DMemReady, MemEn); end
    coreExp = refMem[3];
    cyc(); clearInputs();
    @(negedge Clock);
    checks++; if (CoreRdDataQ104H !== coreExp) begin errors++; $display("FAIL fabst_load got %h exp %h", CoreRdDataQ104H, coreExp); end
    cyc();
  endtask

  task automatic test_ext_in_fab_rsp();
    logic [31:0] d;
    d = $urandom;
    clearInputs();
    CoreRdEnQ103H = 1; CoreAddrQ103H = 32'h0400_0010; CoreByteEnQ103H = 4'hF;
    cyc();
    FabReqReady = 1;
    cyc();
    FabReqReady = 0; ExtReqValid = 1; ExtWrEn = 0; ExtAddr = 12'd7; ExtByteEn = 4'hF;
    @(negedge Clock);
    checks++; if (ExtReqReady !== 1'b1 || MemEn !== 1'b1) begin errors++; $display("FAIL extrsp_grant got %b/%b exp 1/1", ExtReqReady, MemEn); end
    checks++; if (MemAddr !== 12'd7) begin errors++; $display("FAIL extrsp_addr got %h exp 7", MemAddr); end
    checks++; if (DMemReady !== 1'b0) begin errors++; $display("FAIL extrsp_frozen got %b exp 0", DMemReady); end
    cyc();
    ExtReqValid = 0;
    @(negedge Clock);
    checks++; if (ExtRspValid !== 1'b1 || ExtRspData !== refMem[7]) begin errors++; $display("FAIL extrsp_data got %b/%h exp 1/%h", ExtRspValid, ExtRspData, refMem[7]); end
    checks++; if (DMemReady !== 1'b0) begin errors++; $display("FAIL extrsp_frozen2 got %b exp 0", DMemReady); end
    cyc();
    FabRspValid = 1; FabRspData = d;
    cyc();
    FabRspValid = 0;
    @(negedge Clock);
    checks++; if (DMemReady !== 1'b1) begin errors++; $display("FAIL extrsp_done got %b exp 1", DMemReady); end
    cyc(); clearInputs();
    @(negedge Clock);
    checks++; if (CoreRdDataQ104H !== d) begin errors++; $display("FAIL extrsp_core got %h exp %h", CoreRdDataQ104H, d); end
    coreExp = d;
    cyc();
  endtask

  task automatic test_reset_mid();
    clearInputs();
    CoreRdEnQ103H = 1; CoreAddrQ103H = 32'h0500_0000; CoreByteEnQ103H = 4'hF;
    cyc();
    FabReqReady = 1;
    cyc();
    FabReqReady = 0; Rst = 1; ExtReqValid = 1;
    @(negedge Clock);
    checks++; if (DMemReady !== 1'b1 || MemEn !== 1'b0 || ExtReqReady !== 1'b0) begin errors++; $display("FAIL rstmid_vals got %b/%b/%b exp 1/0/0", DMemReady, MemEn, ExtReqReady); end
    checks++; if (CoreRdDataQ104H !== 32'd0 || FabReqValid !== 1'b0) begin errors++; $display("FAIL rstmid_data got %h/%b exp 0/0", CoreRdDataQ104H, FabReqValid); end
    cyc();
    Rst = 0; clearInputs();
    FabRspValid = 1; FabRspData = 32'hBAD0_0BAD;
    @(negedge Clock);
    checks++; if (DMemReady !== 1'b1 || FabReqValid !== 1'b0) begin errors++; $display("FAIL rstmid_idle got %b/%b exp 1/0", DMemReady, FabReqValid); end
    cyc(); clearInputs();
    CoreRdEnQ103H = 1; CoreAddrQ103H = localAddr(2); CoreByteEnQ103H = 4'hF;
    @(negedge Clock);
    checks++; if (CoreRdDataQ104H !== 32'd0) begin errors++; $display("FAIL rstmid_ignored got %h exp 0", CoreRdDataQ104H); end
    checks++; if (MemEn !== 1'b1 || DMemReady !== 1'b1) begin errors++; $display("FAIL rstmid_local got %b/%b exp 1/1", MemEn, DMemReady); end
    cyc(); clearInputs();
    @(negedge Clock);
    checks++; if (CoreRdDataQ104H !== refMem[2]) begin errors++; $display("FAIL rstmid_load got %h exp %h", CoreRdDataQ104H, refMem[2]); end
    cyc();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) refMem[i] = 32'hA500_0000 | 32'(i);
    Rst = 1;
    clearInputs();
    coreExp = 32'd0;
    cyc();
    test_reset();
    test_core_load();
    test_back_to_back();
    test_starvation();
    test_fab_load(2, 3, 32'h0200_0000, 32'h1234_5678);
    for (int i = 0; i < 3; i++)
      test_fab_load($urandom_range(1, 3), $urandom_range(1, 4),
                    32'h0200_0000 + 32'($urandom_range(0, 1023)) * 4, $urandom);
    test_fab_store();
    test_fab_store();
    test_ext_in_fab_rsp();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
